// File: rtl/bitop_sequencer_pkg.sv
// Shared definitions for the bit-operation sequencer and its bit-op unit.
package bitop_sequencer_pkg;

  // Command encodings presented on cmd; 5..7 are illegal.
  localparam logic [2:0] CMD_BIT = 3'd0;
  localparam logic [2:0] CMD_SET = 3'd1;
  localparam logic [2:0] CMD_RES = 3'd2;
  localparam logic [2:0] CMD_RLD = 3'd3;
  localparam logic [2:0] CMD_RRD = 3'd4;

  // Bit-op unit opcodes; BOP_IDLE parks the unit between commands.
  localparam logic [2:0] BOP_GETBIT  = 3'b000;
  localparam logic [2:0] BOP_SETBIT  = 3'b001;
  localparam logic [2:0] BOP_NSETBIT = 3'b010;
  localparam logic [2:0] BOP_GET4    = 3'b011;
  localparam logic [2:0] BOP_PUT4    = 3'b100;
  localparam logic [2:0] BOP_MERGE44 = 3'b101;
  localparam logic [2:0] BOP_IDLE    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EXEC = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic cmd_legal(input logic [2:0] c);
    return c <= CMD_RRD;
  endfunction

  function automatic logic cmd_is_rot(input logic [2:0] c);
    return (c == CMD_RLD) || (c == CMD_RRD);
  endfunction

  // Flag byte S,Z,X,H,X,PV,N,C for an 8-bit data result (PV = even parity).
  function automatic logic [7:0] result_flags(input logic [7:0] r);
    return {r[7], (r == 8'h00), r[5], 1'b0, r[3], ~(^r), 1'b0, 1'b0};
  endfunction

endpackage

// File: rtl/bitop_sequencer_bitops.sv
// Combinational bit-op unit driven by the sequencer's bop_* operand bus.
module bitops
  import bitop_sequencer_pkg::*;
(
  input  logic [2:0]  opp,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  output logic [15:0] out,
  output logic [7:0]  flags
);

  logic [7:0] res8;
  logic       bitv;
  logic       unused_bits;

  assign unused_bits = ^{a[15:8], b[15:4], c[15:3]};

  // Decode the opcode into an 8-bit result and its flag byte.
  always_comb begin
    res8  = 8'h00;
    bitv  = a[c[2:0]];
    out   = 16'h0000;
    flags = 8'h00;
    case (opp)
      BOP_GETBIT: begin
        out   = {15'h0000, bitv};
        flags = {(c[2:0] == 3'd7) & bitv, ~bitv, a[5], 1'b1, a[3], ~bitv, 1'b0, 1'b0};
      end
      BOP_SETBIT: begin
        res8           = a[7:0];
        res8[c[2:0]]   = b[0];
        out            = {8'h00, res8};
        flags          = result_flags(res8);
      end
      BOP_NSETBIT: begin
        res8           = a[7:0];
        res8[c[2:0]]   = ~b[0];
        out            = {8'h00, res8};
        flags          = result_flags(res8);
      end
      BOP_GET4: begin
        res8  = c[0] ? {4'h0, a[7:4]} : {4'h0, a[3:0]};
        out   = {8'h00, res8};
        flags = result_flags(res8);
      end
      BOP_PUT4: begin
        res8  = c[0] ? {b[3:0], a[3:0]} : {a[7:4], b[3:0]};
        out   = {8'h00, res8};
        flags = result_flags(res8);
      end
      BOP_MERGE44: begin
        res8  = {a[3:0], b[3:0]};
        out   = {8'h00, res8};
        flags = result_flags(res8);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/bitop_sequencer.sv
// Sequencer for Z80-style BIT/SET/RES/RLD/RRD using an external bit-op unit.
module bitop_sequencer
  import bitop_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  cmd,
  input  logic [2:0]  bit_sel,
  input  logic        use_mem,
  input  logic [7:0]  reg_val,
  input  logic [7:0]  acc_in,
  input  logic [7:0]  flags_in,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic [15:0] bop_out,
  input  logic [7:0]  bop_flags,
  output logic [2:0]  bop_opp,
  output logic [15:0] bop_a,
  output logic [15:0] bop_b,
  output logic [15:0] bop_c,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  output logic        acc_we,
  output logic [7:0]  acc_wdata,
  output logic        flags_we,
  output logic [7:0]  flags_out,
  output logic        busy,
  output logic        done
);

  state_t     state, state_nxt;
  logic [1:0] step, step_nxt;
  logic [2:0] cmd_q, bit_q;
  logic       mem_q;
  logic [7:0] acc_q, flags_q, opnd;
  logic [7:0] res_m, res_a, flag_res;
  logic [3:0] nib_t, nib_u;
  logic       four_step, last_step, in_done;
  logic       unused_bits;

  assign unused_bits = ^bop_out[15:8];
  assign four_step   = cmd_is_rot(cmd_q);
  assign last_step   = four_step ? (step == 2'd3) : 1'b1;
  assign in_done     = (state == S_DONE);

  // State and step registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= 2'd0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE, mem_ack only in RD/WR.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      S_IDLE: begin
        if (start) begin
          step_nxt = 2'd0;
          if (!cmd_legal(cmd))                state_nxt = S_DONE;
          else if (use_mem || cmd_is_rot(cmd)) state_nxt = S_RD;
          else                                 state_nxt = S_EXEC;
        end
      end
      S_RD: begin
        if (mem_ack) begin
          state_nxt = S_EXEC;
          step_nxt  = 2'd0;
        end
      end
      S_EXEC: begin
        if (last_step) begin
          step_nxt  = 2'd0;
          state_nxt = (mem_q && (cmd_q != CMD_BIT)) ? S_WR : S_DONE;
        end else begin
          step_nxt = step + 2'd1;
        end
      end
      S_WR: begin
        if (mem_ack) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: begin
        state_nxt = S_IDLE;
        step_nxt  = 2'd0;
      end
    endcase
  end

  // Command latches and per-step result capture from the bit-op unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= 3'd0;
      bit_q    <= 3'd0;
      mem_q    <= 1'b0;
      acc_q    <= 8'h00;
      flags_q  <= 8'h00;
      opnd     <= 8'h00;
      res_m    <= 8'h00;
      res_a    <= 8'h00;
      flag_res <= 8'h00;
      nib_t    <= 4'h0;
      nib_u    <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_q   <= cmd;
            bit_q   <= bit_sel;
            mem_q   <= use_mem || cmd_is_rot(cmd);
            acc_q   <= acc_in;
            flags_q <= flags_in;
            opnd    <= reg_val;
          end
        end
        S_RD: begin
          if (mem_ack) opnd <= mem_rdata;
        end
        S_EXEC: begin
          if (cmd_q == CMD_BIT) begin
            flag_res <= {bop_flags[7:1], flags_q[0]};
          end else if (!four_step) begin
            res_m <= bop_out[7:0];
          end else begin
            case (step)
              2'd0: nib_t <= bop_out[3:0];
              2'd1: res_m <= bop_out[7:0];
              2'd2: nib_u <= bop_out[3:0];
              default: begin
                res_a    <= bop_out[7:0];
                flag_res <= {bop_flags[7:5], 1'b0, bop_flags[3:2], 1'b0, flags_q[0]};
              end
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bit-op unit operands; the unit is parked whenever we are not executing.
  always_comb begin
    bop_opp = BOP_IDLE;
    bop_a   = 16'h0000;
    bop_b   = 16'h0000;
    bop_c   = 16'h0000;
    if (state == S_EXEC) begin
      case (cmd_q)
        CMD_BIT: begin
          bop_opp = BOP_GETBIT;
          bop_a   = {8'h00, opnd};
          bop_c   = {13'h0000, bit_q};
        end
        CMD_SET, CMD_RES: begin
          bop_opp = (cmd_q == CMD_SET) ? BOP_SETBIT : BOP_NSETBIT;
          bop_a   = {8'h00, opnd};
          bop_b   = 16'h0001;
          bop_c   = {13'h0000, bit_q};
        end
        CMD_RLD, CMD_RRD: begin
          case (step)
            2'd0: begin
              bop_opp = BOP_GET4;
              bop_a   = {8'h00, opnd};
              bop_c   = 16'h0001;
            end
            2'd1: begin
              bop_opp = BOP_MERGE44;
              bop_a   = (cmd_q == CMD_RLD) ? {8'h00, opnd}  : {8'h00, acc_q};
              bop_b   = (cmd_q == CMD_RLD) ? {8'h00, acc_q} : {12'h000, nib_t};
            end
            2'd2: begin
              bop_opp = BOP_GET4;
              bop_a   = {8'h00, acc_q};
              bop_c   = 16'h0001;
            end
            default: begin
              bop_opp = BOP_MERGE44;
              bop_a   = {12'h000, nib_u};
              bop_b   = (cmd_q == CMD_RLD) ? {12'h000, nib_t} : {8'h00, opnd};
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake, status and write-back outputs, all decoded from the current state.
  always_comb begin
    busy      = (state != S_IDLE);
    mem_req   = (state == S_RD) || (state == S_WR);
    mem_we    = (state == S_WR);
    mem_wdata = (state == S_WR) ? res_m : 8'h00;
    done      = in_done;
    reg_we    = in_done && !mem_q && ((cmd_q == CMD_SET) || (cmd_q == CMD_RES));
    acc_we    = in_done && four_step;
    flags_we  = in_done && ((cmd_q == CMD_BIT) || four_step);
    reg_wdata = reg_we   ? res_m    : 8'h00;
    acc_wdata = acc_we   ? res_a    : 8'h00;
    flags_out = flags_we ? flag_res : 8'h00;
  end

endmodule

// File: doc/bitop_sequencer.md
BITOP_SEQUENCER -- requirements
Module: bitop_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  command strobe, sampled in IDLE only
- cmd  in  3  0=BIT, 1=SET, 2=RES, 3=RLD, 4=RRD, 5-7 illegal
- bit_sel  in  3  bit index for BIT/SET/RES
- use_mem  in  1  operand is (HL) memory, not register; ignored (treated as 1) for RLD/RRD
- reg_val  in  8  register operand
- acc_in  in  8  accumulator
- flags_in  in  8  current flags S,Z,X,H,X,PV,N,C
- mem_rdata  in  8  memory read data
- mem_ack  in  1  memory transfer complete
- bop_out  in  16  bit-op unit result
- bop_flags  in  8  bit-op unit flags
- bop_opp  out  3  bit-op unit opcode
- bop_a, bop_b, bop_c  out  16 each  bit-op unit operands
- mem_req, mem_we  out  1 each  memory request, write qualifier
- mem_wdata  out  8  memory write data
- reg_we / reg_wdata  out  1 / 8  register write-back
- acc_we / acc_wdata  out  1 / 8  accumulator write-back
- flags_we / flags_out  out  1 / 8  flag write-back
- busy, done  out  1 each  command in progress; one-cycle completion pulse

Function
REQ-003 FSM states SHALL be IDLE, RD, EXEC, WR, DONE; EXEC carries a 2-bit step counter.
REQ-004 IDLE + start: latch cmd, bit_sel, use_mem, acc_in, flags_in, reg_val (into opnd); go to RD if memory operand, else EXEC step 0; start outside IDLE SHALL be ignored.
REQ-005 RD: mem_req=1, mem_we=0 until mem_ack; on mem_ack latch mem_rdata into opnd, go to EXEC step 0.
REQ-006 bop_opp SHALL be 3'b111 and bop_a/b/c zero outside EXEC; operands zero-extended to 16 bits; results use bop_out[7:0] (get4 results bop_out[3:0]), captured at end of each EXEC step.
REQ-007 BIT: one step, getbit(A=opnd, C=bit_sel); flags_out = bop_flags[7:1] with bit0 = latched flags_in[0]; no data write.
REQ-008 SET/RES: one step, setbit/nsetbit(A=opnd, B=1, C=bit_sel); flags unchanged (flags_we=0).
REQ-009 RLD: 4 steps: t=get4(opnd,C=1); m=merge44(A=opnd,B=acc); u=get4(acc,C=1); a=merge44(A=u,B=t); mem result m, acc result a.
REQ-010 RRD: 4 steps: t=get4(opnd,C=1); m=merge44(A=acc,B=t); u=get4(acc,C=1); a=merge44(A=u,B=opnd).
REQ-011 RLD/RRD flags_out = final-step bop_flags with H=0, N=0, C = latched flags_in[0].
REQ-012 After last step: memory-operand SET/RES/RLD/RRD go to WR; else DONE.
REQ-013 WR: mem_req=1, mem_we=1, mem_wdata=result held stable until mem_ack, then DONE.
REQ-014 DONE (one cycle): done=1; reg_we (register SET/RES), acc_we (RLD/RRD), flags_we (BIT/RLD/RRD) pulse with done; return to IDLE.
REQ-015 Latency: register BIT/SET/RES done 2 cycles after start sampled; memory BIT = 3 + RD wait cycles; RLD/RRD = 7 + RD and WR wait cycles (zero-wait: 7).
REQ-016 Illegal cmd: IDLE -> DONE directly, done=1, all write enables 0.
REQ-017 busy=1 in every state except IDLE; mem_ack outside RD/WR ignored.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, step=0, all latches and outputs 0 (bop_opp=3'b111); mid-command reset SHALL produce no write-back or done.

Structure
REQ-019 Shared package SHALL hold cmd encodings, bit-op opcodes (000 getbit … 101 merge44, 111 idle) and state encoding.
REQ-020 One sub-module natural: the bit-op unit (bitops) instantiated alongside, not inside; sequencer is standalone.

Verification
REQ-021 Reg BIT: cmd=0, bit_sel=3, reg_val=0x08 -> done at +2, flags_out[6](Z)=0, flags_out[0]=flags_in[0], no reg_we.
REQ-022 Reg RES: cmd=2, bit_sel=7, reg_val=0xFF -> reg_wdata=0x7F with reg_we and done at +2, flags_we=0.
REQ-023 Mem SET: cmd=1, bit_sel=0, mem_rdata=0x10, 2-cycle ack delays on read and write -> mem_wdata=0x11 held until ack, done once.
REQ-024 RLD: acc=0x7A, mem=0x31 -> mem_wdata=0x1A, acc_wdata=0x73, PV=0, Z=0; RRD same inputs -> mem_wdata=0xA3, acc_wdata=0x71.
REQ-025 rst_n low during WR of RLD -> outputs 0 asynchronously, no acc_we/done; subsequent start works normally.
REQ-026 start during busy and cmd=6 -> ignored; illegal completes in 1 cycle with no enables.
